// File: rtl/l15_port_arbiter.sv
// Shares the single L1.5 transducer port among NUM_REQ clients, locking one owner per transaction.
// Optional macro L15_ARB_FIXED_PRIO_EN: lowest index always wins instead of round-robin.
module l15_port_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic [5*NUM_REQ-1:0]        req_rqtype,
  input  logic [3*NUM_REQ-1:0]        req_size,
  input  logic [ADDR_W*NUM_REQ-1:0]   req_address,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_val,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [NUM_REQ-1:0]          req_header_ack,
  output logic [NUM_REQ-1:0]          rsp_val,
  output logic [63:0]                 rsp_data_0,
  output logic [63:0]                 rsp_data_1,
  output logic [3:0]                  rsp_returntype,
  input  logic [NUM_REQ-1:0]          rsp_ack,
  output logic [4:0]                  transducer_l15_rqtype,
  output logic [2:0]                  transducer_l15_size,
  output logic [ADDR_W-1:0]           transducer_l15_address,
  output logic [DATA_W-1:0]           transducer_l15_data,
  output logic                        transducer_l15_val,
  input  logic                        l15_transducer_ack,
  input  logic                        l15_transducer_header_ack,
  input  logic                        l15_transducer_val,
  input  logic [63:0]                 l15_transducer_data_0,
  input  logic [63:0]                 l15_transducer_data_1,
  input  logic [3:0]                  l15_transducer_returntype,
  output logic                        transducer_l15_req_ack,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   win_idx;
  logic               win_found;
  int unsigned        cand;

  logic [4:0]         sel_rqtype;
  logic [2:0]         sel_size;
  logic [ADDR_W-1:0]  sel_address;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_val;
  logic               sel_rsp_ack;
  logic [IDX_W-1:0]   gidx_inc;

  // Winner search starting at the round-robin pointer, wrapping past NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef L15_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`endif
      if (!win_found && req_val[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Payload mux selected by the registered grant index.
  always_comb begin
    sel_rqtype  = '0;
    sel_size    = '0;
    sel_address = '0;
    sel_data    = '0;
    sel_val     = 1'b0;
    sel_rsp_ack = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        sel_rqtype  = req_rqtype[5*i +: 5];
        sel_size    = req_size[3*i +: 3];
        sel_address = req_address[ADDR_W*i +: ADDR_W];
        sel_data    = req_data[DATA_W*i +: DATA_W];
        sel_val     = req_val[i];
        sel_rsp_ack = rsp_ack[i];
      end
    end
  end

  assign gidx_inc = (gidx_q == IDX_W'(NUM_REQ-1)) ? '0 : gidx_q + IDX_W'(1);

  always_comb begin
    state_d                = state_q;
    gidx_d                 = gidx_q;
    rr_ptr_d               = rr_ptr_q;
    req_ack                = '0;
    req_header_ack         = '0;
    rsp_val                = '0;
    transducer_l15_rqtype  = '0;
    transducer_l15_size    = '0;
    transducer_l15_address = '0;
    transducer_l15_data    = '0;
    transducer_l15_val     = 1'b0;
    transducer_l15_req_ack = 1'b0;
    case (state_q)
      IDLE: begin
        transducer_l15_req_ack = l15_transducer_val;
        if (win_found) begin
          state_d = REQ;
          gidx_d  = win_idx;
        end
      end
      REQ: begin
        transducer_l15_rqtype  = sel_rqtype;
        transducer_l15_size    = sel_size;
        transducer_l15_address = sel_address;
        transducer_l15_data    = sel_data;
        transducer_l15_val     = sel_val;
        req_ack                = NUM_REQ'(l15_transducer_ack) << gidx_q;
        req_header_ack         = NUM_REQ'(l15_transducer_header_ack) << gidx_q;
        // A response alongside the ack belongs to this request; L1.5 holds it into RESP.
        transducer_l15_req_ack = l15_transducer_val && !l15_transducer_ack;
        if (l15_transducer_ack) state_d = RESP;
        else if (!sel_val)      state_d = IDLE;
      end
      RESP: begin
        rsp_val                = NUM_REQ'(l15_transducer_val) << gidx_q;
        transducer_l15_req_ack = sel_rsp_ack;
        if (l15_transducer_val && sel_rsp_ack) begin
          state_d = IDLE;
`ifdef L15_ARB_FIXED_PRIO_EN
          rr_ptr_d = '0;
`else
          rr_ptr_d = gidx_inc;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      grant    <= '0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      grant    <= (state_d == IDLE) ? '0 : (NUM_REQ'(1) << gidx_d);
    end
  end

  assign busy           = (state_q != IDLE);
  assign rsp_data_0     = l15_transducer_data_0;
  assign rsp_data_1     = l15_transducer_data_1;
  assign rsp_returntype = l15_transducer_returntype;

endmodule
